mdu_iter: RTL
=============

# mdu_iter

Parametrised iterative multiply/divide unit for the execute stage of the pipelined MIPS core. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the HI/LO registers. It runs multi-cycle operations off to the side of the main ALU and raises `busy`, so the hazard unit stalls dependent MFHI/MFLO and any later multiply/divide. The width is generic, so the same block serves the 32-bit core and narrower test configurations.

## Interface
- `WIDTH`, 32, operand and HI/LO width; even, ≥4
- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset, asynchronous, active-low
- `startE`  in  1  issue `opE` this cycle
- `opE`  in  3  operation code, `mdu_op_t`
- `srcaE`  in  WIDTH  forwarded rs operand
- `srcbE`  in  WIDTH  forwarded rt operand
- `abortE`  in  1  cancel the in-flight or issuing operation (E flush)
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register
- `busy`  out  1  multi-cycle operation in flight
- `done`  out  1  one-cycle pulse: HI/LO have just been updated by MULT*/DIV*

## Operation
- **Reset** (`reset`=0, asynchronous):
  - `hi`=`lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- **FSM states:** IDLE, MUL, DIV, FIX.
- **IDLE** with `startE`=1 and `abortE`=0:
  - MTHI/MTLO: write `srcaE` to HI/LO at that edge. No `busy`, no `done`.
  - MULT/MULTU: latch operand magnitudes and the result sign, then go to MUL. The latched sign is `a[W-1]^b[W-1]` for signed, 0 for unsigned.
  - DIV/DIVU with `srcbE`=0: go to FIX with a preset result, HI=`srcaE`, LO=all ones.
  - DIV/DIVU with `srcbE`≠0: latch magnitudes plus the quotient and remainder signs, then go to DIV.
- **MUL:** shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. After WIDTH cycles go to FIX.
- **DIV:** restoring division, one quotient bit per cycle through `mdu_div_step`. After WIDTH cycles go to FIX.
- **FIX:**
  - Negate the product if its sign is set.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - Write HI/LO (HI = product high half or remainder; LO = product low half or quotient), pulse `done`, return to IDLE.
- **Signed overflow:** −2^(W−1) / −1 gives LO=0x8000_0000, HI=0 (wraps, no trap).
- **Issue while busy:** `startE` while `busy`=1 is ignored. The hazard unit guarantees this does not occur; the RTL does not rely on that guarantee.
- **`abortE`:**
  - In MUL/DIV/FIX: go to IDLE at the next edge. HI/LO are unchanged and `done` is not pulsed.
  - In IDLE together with `startE`: abort wins, and nothing is written or issued.
- **Arithmetic:** all internal arithmetic is unsigned on magnitudes. Counter width is `$clog2(WIDTH+1)`.

## Timing
- Let the start be sampled at edge t.
- **MULT/MULTU and non-zero DIV/DIVU:**
  - `busy`=1 from after edge t until edge t+WIDTH+1.
  - HI/LO are updated at edge t+WIDTH+1.
  - `done`=1 for the cycle following edge t+WIDTH+1.
  - Latency is 33 edges at WIDTH=32.
- **Divide by zero:** `busy` is high for one cycle; HI/LO update and `done` follow edge t+1.
- **MTHI/MTLO:** visible on `hi`/`lo` after edge t.
- **Outputs:** `busy`, `done`, `hi` and `lo` are all registered. No combinational input-to-output paths.
- **Reset mid-operation:** outputs clear immediately, without waiting for a clock edge.

## Configuration
- **`MDU_FAST_MUL_EN` defined:**
  - MULT/MULTU compute the full signed or unsigned product in a single MUL cycle, skip FIX, and write HI/LO at edge t+1.
  - `busy` is high for one cycle and `done` follows edge t+1.
  - Division is unchanged.
- **Not defined:** the iterative multiplier described above. There is no combinational WIDTH×WIDTH multiplier.

## Structure
- `mdu_pkg` holds:
  - `mdu_op_t` enum: NOP=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
  - `mdu_state_t` enum: IDLE, MUL, DIV, FIX.
- Sub-module `mdu_div_step #(WIDTH)`, combinational, one restoring-division step:
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.

## Test plan
All scenarios at WIDTH=32.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, `done` after edge t+33 (t+1 with `MDU_FAST_MUL_EN`).
- MULT −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIVU 100/7 → LO=14, HI=2. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5/0 → HI=5, LO=0xFFFFFFFF, `busy` high one cycle, `done` after edge t+1.
- DIV issued, `abortE` at cycle 10 → `busy`=0 next edge, HI/LO keep prior values, no `done`. A second `startE` at cycle 5 of a MULT is ignored (result equals the first op only).
- `reset` low at cycle 5 of a MULT → `hi`/`lo`/`busy`/`done` are 0 immediately. After release, MTLO 0x1234 → `lo`=0x1234 next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the iterative multiply/divide unit.
//   mdu_op_t    - operation code presented on opE (3 bits)
//   mdu_state_t - control FSM state, also visible on mdu_iter.o_dbg_state
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step on unsigned values.
// Ports:
//   i_rem     - current partial remainder (always < i_divisor)
//   i_divisor - divisor magnitude (non-zero)
//   i_bit     - next dividend bit shifted into the remainder
//   o_rem     - new partial remainder
//   o_qbit    - quotient bit produced by this step
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;

    assign w_trial = {i_rem, i_bit};
    // The comparison uses the full W+1-bit trial value; when it succeeds the
    // difference is below the divisor, so W bits are enough to hold it.
    assign o_qbit  = (w_trial >= {1'b0, i_divisor});
    assign w_diff  = w_trial[WIDTH-1:0] - i_divisor;
    assign o_rem   = o_qbit ? w_diff : w_trial[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning the HI/LO registers.
// Implements MULT, MULTU, DIV, DIVU (multi-cycle) and MTHI, MTLO (single edge).
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle multiply).
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   startE, opE       - issue request and operation code (mdu_op_t)
//   srcaE, srcbE      - rs / rt operands
//   abortE            - cancel the in-flight or issuing operation
//   hi, lo            - HI/LO registers
//   busy              - multi-cycle operation in flight
//   done              - one-cycle pulse after HI/LO were written by MULT*/DIV*
//   o_dbg_state       - current FSM state (mdu_state_t encoding)
//
// Handshake: startE is a one-cycle request that is accepted only in IDLE
// (busy=0) and when abortE is low; a request seen while busy is dropped.
// Completion is signalled by done one cycle after the final edge.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [2:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             abortE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t         r_state, w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // MUL: {partial, multiplier}; DIV: {rem, dividend/quotient}
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic               r_neg_hi;   // negate HI half (remainder sign / product sign)
    logic               r_neg_lo;   // negate LO half (quotient sign / product sign)
    logic               r_is_div;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_busy, r_done;

    mdu_op_t            w_op;
    logic               w_issue, w_signed_op, w_a_neg, w_b_neg, w_last;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_op        = mdu_op_t'(opE);
    assign w_issue     = (r_state == ST_IDLE) && startE && !abortE;
    assign w_signed_op = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_a_neg     = w_signed_op && srcaE[WIDTH-1];
    assign w_b_neg     = w_signed_op && srcbE[WIDTH-1];
    assign w_mag_a     = w_a_neg ? (~srcaE + 1'b1) : srcaE;
    assign w_mag_b     = w_b_neg ? (~srcbE + 1'b1) : srcbE;
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_divisor (r_opnd),
        .i_bit     (r_acc[WIDTH-1]),
        .o_rem     (w_div_rem),
        .o_qbit    (w_div_q)
    );

`ifdef MDU_FAST_MUL_EN
    // Raw operands are latched; the product is formed in the single MUL cycle.
    logic               r_signed;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_fast_prod;
    assign w_ext_a     = {{WIDTH{r_signed & r_opnd[WIDTH-1]}}, r_opnd};
    assign w_ext_b     = {{WIDTH{r_signed & r_acc[WIDTH-1]}}, r_acc[WIDTH-1:0]};
    assign w_fast_prod = w_ext_a * w_ext_b;
`else
    // Shift-add: the multiplier sits in the low half and is consumed LSB first
    // while the partial product shifts in from the top, carry included.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};
`endif

    // Sign fix-up: a product negates as one 2W value, div halves independently.
    always_comb begin
        w_prod   = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
            w_fix_lo = r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    case (w_op)
                        OP_MULT, OP_MULTU: w_next_state = ST_MUL;
                        OP_DIV, OP_DIVU:   w_next_state = (srcbE == '0) ? ST_FIX : ST_DIV;
                        default:           w_next_state = ST_IDLE;
                    endcase
                end
            end
`ifdef MDU_FAST_MUL_EN
            ST_MUL:  w_next_state = ST_IDLE;
`else
            ST_MUL:  w_next_state = w_last ? ST_FIX : ST_MUL;
`endif
            ST_DIV:  w_next_state = w_last ? ST_FIX : ST_DIV;
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && abortE) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MDU_FAST_MUL_EN
            r_signed <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_issue) begin
                        case (w_op)
                            OP_MTHI: r_hi <= srcaE;
                            OP_MTLO: r_lo <= srcaE;
                            OP_MULT, OP_MULTU: begin
                                r_is_div <= 1'b0;
`ifdef MDU_FAST_MUL_EN
                                r_opnd   <= srcaE;
                                r_acc    <= {{WIDTH{1'b0}}, srcbE};
                                r_signed <= w_signed_op;
`else
                                r_opnd   <= w_mag_a;
                                r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                                r_neg_hi <= w_a_neg ^ w_b_neg;
                                r_neg_lo <= w_a_neg ^ w_b_neg;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                r_is_div <= 1'b1;
                                if (srcbE == '0) begin
                                    // Preset result goes straight through FIX unmodified.
                                    r_acc    <= {srcaE, {WIDTH{1'b1}}};
                                    r_neg_hi <= 1'b0;
                                    r_neg_lo <= 1'b0;
                                end else begin
                                    r_opnd   <= w_mag_b;
                                    r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                                    r_neg_hi <= w_a_neg;
                                    r_neg_lo <= w_a_neg ^ w_b_neg;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (!abortE) begin
`ifdef MDU_FAST_MUL_EN
                        r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                        r_lo   <= w_fast_prod[WIDTH-1:0];
                        r_done <= 1'b1;
`else
                        r_acc  <= w_mul_next;
                        r_cnt  <= r_cnt + 1'b1;
`endif
                    end
                end
                ST_DIV: begin
                    if (!abortE) begin
                        r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_q};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!abortE) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule
